// File: rtl/full_adder_pkg.sv
// Shared helpers for the full_adder datapath leaf.
package full_adder_pkg;

  // Signed overflow: operands agree in sign but the sum's sign differs.
  function automatic logic signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit full adder cell used as a link of the ripple chain.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : full_adder_bit

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with a combinational result and a
// registered copy carrying a signed-overflow flag and a valid strobe.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  output logic [WIDTH-1:0] out,
  output logic             cout,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] out_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             vld_q
);

  localparam int unsigned MSB = WIDTH - 1;

  // carry[i] feeds cell i; carry[WIDTH] is the adder's carry out.
  logic [WIDTH:0] carry;
  logic           ovf;

  assign carry[0] = cin;

  // Ripple chain of 1-bit cells, LSB first.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_bit u_cell (
      .a  (num1[i]),
      .b  (num2[i]),
      .ci (carry[i]),
      .s  (out[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
  assign ovf  = signed_ovf(num1[MSB], num2[MSB], out[MSB]);

  // Result register: load on en, valid strobes only for a loading cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= en;
      if (en) begin
        out_q  <= out;
        cout_q <= cout;
        ovf_q  <= ovf;
      end
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  logic clk;
  logic rst_n;

  // WIDTH=1 instance signals
  logic a1, b1, cin1, en1;
  logic s1, co1, q1, cq1, oq1, vq1;

  // WIDTH=8 instance signals
  logic [7:0] a8, b8;
  logic       cin8, en8;
  logic [7:0] s8, q8;
  logic       co8, cq8, oq8, vq8;

  int n_vec;
  int n_err;

  full_adder #(.WIDTH(1)) u_dut1 (
    .out(s1), .cout(co1), .num1(a1), .num2(b1), .cin(cin1),
    .clk(clk), .rst_n(rst_n), .en(en1),
    .out_q(q1), .cout_q(cq1), .ovf_q(oq1), .vld_q(vq1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .out(s8), .cout(co8), .num1(a8), .num2(b8), .cin(cin8),
    .clk(clk), .rst_n(rst_n), .en(en8),
    .out_q(q8), .cout_q(cq8), .ovf_q(oq8), .vld_q(vq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic a, b, c;
    logic s, co, ovf;
  } vec1_t;

  vec1_t tbl [8];

  // Reference values for the 8-bit adder computed with plain integer arithmetic.
  int unsigned ref_sum;
  int          ref_ssum;
  logic [7:0]  m_out;
  logic        m_cout, m_ovf, m_vld;
  logic        load;

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; en1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; en8 = 1'b0;

    // Reset state, including across an edge with en high.
    @(negedge clk);
    en1 = 1'b1; en8 = 1'b1;
    @(posedge clk); #1;
    check("reset_regs8", {24'd0, q8}, 32'd0);
    check("reset_flags8", {29'd0, cq8, oq8, vq8}, 32'd0);
    check("reset_regs1", {28'd0, q1, cq1, oq1, vq1}, 32'd0);
    @(negedge clk);
    en1 = 1'b0; en8 = 1'b0;
    rst_n = 1'b1;

    // 1-bit truth table: combinational after 1 ns, registered after an edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = tbl[i].a; b1 = tbl[i].b; cin1 = tbl[i].c; en1 = 1'b1;
      #1;
      check($sformatf("w1_comb[%0d]", i), {30'd0, co1, s1}, {30'd0, tbl[i].co, tbl[i].s});
      @(posedge clk); #1;
      check($sformatf("w1_reg[%0d]", i), {28'd0, cq1, q1, oq1, vq1},
            {28'd0, tbl[i].co, tbl[i].s, tbl[i].ovf, 1'b1});
    end
    @(negedge clk);
    en1 = 1'b0;

    // 8-bit boundaries.
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; #1;
    check("ff_plus_1", {23'd0, co8, s8}, {23'd0, 1'b1, 8'h00});
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
    check("ff_ff_1", {23'd0, co8, s8}, {23'd0, 1'b1, 8'hFF});
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
    check("ff_0_1_wrap", {23'd0, co8, s8}, {23'd0, 1'b1, 8'h00});

    // Signed overflow 7F + 01.
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; en8 = 1'b1; #1;
    check("7f_plus_1", {23'd0, co8, s8}, {23'd0, 1'b0, 8'h80});
    @(posedge clk); #1;
    check("7f_ovf_q", {22'd0, q8, oq8, vq8}, {22'd0, 8'h80, 1'b1, 1'b1});

    // Load 12+34+1, then hold with en low.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; en8 = 1'b1;
    @(posedge clk); #1;
    check("load_47", {21'd0, q8, cq8, oq8, vq8}, {21'd0, 8'h47, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    en8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    @(posedge clk); #1;
    check("hold_47", {21'd0, q8, cq8, oq8, vq8}, {21'd0, 8'h47, 1'b0, 1'b0, 1'b0});

    // Asynchronous reset between edges after a load.
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1; en8 = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_load", {21'd0, q8, cq8, oq8, vq8}, {21'd0, 8'h11, 1'b1, 1'b0, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_regs", {21'd0, q8, cq8, oq8, vq8}, 32'd0);
    check("async_rst_comb", {23'd0, co8, s8}, {23'd0, 1'b1, 8'h11});
    @(posedge clk); #1;
    check("rst_hold", {21'd0, q8, cq8, oq8, vq8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en8 = 1'b0;

    // Random 8-bit vectors against an arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      load = (i == 0) ? 1'b1 : 1'($urandom);
      en8 = load;
      ref_sum  = int'(a8) + int'(b8) + int'(cin8);
      ref_ssum = int'($signed(a8)) + int'($signed(b8)) + int'(cin8);
      #1;
      check("rand_comb", {23'd0, co8, s8}, 32'(ref_sum));
      if (load) begin
        m_out  = 8'(ref_sum);
        m_cout = ref_sum > 255;
        m_ovf  = (ref_ssum > 127) || (ref_ssum < -128);
      end
      m_vld = load;
      @(posedge clk); #1;
      check("rand_reg", {21'd0, q8, cq8, oq8, vq8}, {21'd0, m_out, m_cout, m_ovf, m_vld});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_full_adder
